alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_pkg.sv | 38 +++
 rtl/fp_add_sub.sv | 71 +++++++
 rtl/alu.sv | 102 ++++++++++
 tb/tb_alu.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared binary32 constants and the common round/pack helper.
// Used by the ALU top and its add/sub datapath.
package alu_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  EXP_MAX = 8'hFF;

  // m holds 1.f (24 bits) followed by guard, round, sticky; e is biased.
  function automatic logic [31:0] fp_round(
    input logic              s,
    input logic signed [9:0] e,
    input logic [26:0]       m
  );
    logic              rup;
    logic [24:0]       sig;
    logic signed [9:0] er;
    logic [22:0]       frac;
    rup  = m[2] & (m[1] | m[0] | m[3]);
    sig  = {1'b0, m[26:3]} + {24'd0, rup};
    er   = sig[24] ? e + 10'sd1 : e;
    frac = sig[24] ? sig[23:1] : sig[22:0];
    if (er >= 10'sd255) begin
      return {s, EXP_MAX, 23'd0};
    end else if (er <= 10'sd0) begin
      return {s, 31'd0};
    end
    return {s, er[7:0], frac};
  endfunction

endpackage

// File: rtl/fp_add_sub.sv
// Combinational binary32 add/subtract for finite, non-zero normal operands.
// Zero, infinity and NaN handling is done by the caller.
module fp_add_sub
  import alu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        sub_i,
  output logic [31:0] y_o
);

  logic              a_big;
  logic              sb;
  logic              s_l;
  logic              s_s;
  logic              eff_sub;
  logic [7:0]        e_l;
  logic [7:0]        e_s;
  logic [7:0]        d;
  logic [26:0]       m_l;
  logic [26:0]       m_s;
  logic [26:0]       m_al;
  logic [26:0]       m_n;
  logic [53:0]       sh;
  logic [27:0]       sum;
  logic [4:0]        lz;
  logic              found;
  logic signed [9:0] e_n;

  always_comb begin
    sb    = b_i[31] ^ sub_i;
    a_big = a_i[30:0] >= b_i[30:0];
    s_l   = a_big ? a_i[31] : sb;
    s_s   = a_big ? sb : a_i[31];
    e_l   = a_big ? a_i[30:23] : b_i[30:23];
    e_s   = a_big ? b_i[30:23] : a_i[30:23];
    m_l   = a_big ? {1'b1, a_i[22:0], 3'b000}
                  : {1'b1, b_i[22:0], 3'b000};
    m_s   = a_big ? {1'b1, b_i[22:0], 3'b000}
                  : {1'b1, a_i[22:0], 3'b000};
    d     = e_l - e_s;
    sh    = {m_s, 27'd0} >> d;
    // Bits shifted past the round position fold into the sticky bit.
    m_al  = (d >= 8'd26) ? 27'd1
          : {sh[53:28], sh[27] | (|sh[26:0])};
    eff_sub = s_l ^ s_s;
    sum = eff_sub ? {1'b0, m_l} - {1'b0, m_al}
                  : {1'b0, m_l} + {1'b0, m_al};

    lz    = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found) begin
        if (sum[i]) found = 1'b1;
        else        lz    = lz + 5'd1;
      end
    end

    if (sum[27]) begin
      m_n = {sum[27:2], sum[1] | sum[0]};
      e_n = $signed({2'b00, e_l}) + 10'sd1;
    end else begin
      m_n = sum[26:0] << lz;
      e_n = $signed({2'b00, e_l}) - $signed({5'd0, lz});
    end

    if (sum == 28'd0) y_o = 32'h0000_0000;
    else              y_o = fp_round(s_l, e_n, m_n);
  end

endmodule

// File: rtl/alu.sv
// Single-cycle binary32 ALU: ADD, SUB, MUL with registered result.
// Special operands are resolved here; finite add/sub goes to fp_add_sub.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OPERATIONCODE,
  output logic [WIDTH-1:0] O
);

  logic              sa;
  logic              sb;
  logic              sbe;
  logic [7:0]        ea;
  logic [7:0]        eb;
  logic [22:0]       fa;
  logic [22:0]       fb;
  logic              a_nan;
  logic              b_nan;
  logic              a_inf;
  logic              b_inf;
  logic              a_zero;
  logic              b_zero;
  logic              is_sub;
  logic [31:0]       as_y;
  logic [31:0]       add_y;
  logic [31:0]       mul_y;
  logic [47:0]       prod;
  logic [26:0]       pm;
  logic signed [9:0] pe;
  logic [31:0]       o_d;
  logic [31:0]       o_q;

  assign is_sub = OPERATIONCODE == OP_SUB;

  fp_add_sub u_add_sub (
    .a_i   (A[31:0]),
    .b_i   (B[31:0]),
    .sub_i (is_sub),
    .y_o   (as_y)
  );

  always_comb begin
    sa = A[31];
    sb = B[31];
    ea = A[30:23];
    eb = B[30:23];
    fa = A[22:0];
    fb = B[22:0];
    sbe = sb ^ is_sub;
    a_nan  = (ea == EXP_MAX) && (fa != 23'd0);
    b_nan  = (eb == EXP_MAX) && (fb != 23'd0);
    a_inf  = (ea == EXP_MAX) && (fa == 23'd0);
    b_inf  = (eb == EXP_MAX) && (fb == 23'd0);
    a_zero = ea == 8'd0;
    b_zero = eb == 8'd0;

    if (a_nan | b_nan)       add_y = QNAN;
    else if (a_inf & b_inf)  add_y = (sa == sbe) ? A[31:0] : QNAN;
    else if (a_inf)          add_y = A[31:0];
    else if (b_inf)          add_y = {sbe, EXP_MAX, 23'd0};
    else if (a_zero & b_zero) add_y = {sa & sbe, 31'd0};
    else if (b_zero)         add_y = A[31:0];
    else if (a_zero)         add_y = {sbe, B[30:0]};
    else                     add_y = as_y;

    prod = {24'd0, 1'b1, fa} * {24'd0, 1'b1, fb};
    pe   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    if (prod[47]) begin
      pm = {prod[47:22], |prod[21:0]};
      pe = pe + 10'sd1;
    end else begin
      pm = {prod[46:21], |prod[20:0]};
    end

    if (a_nan | b_nan)                         mul_y = QNAN;
    else if ((a_inf & b_zero) | (a_zero & b_inf)) mul_y = QNAN;
    else if (a_inf | b_inf)                    mul_y = {sa ^ sb, EXP_MAX, 23'd0};
    else if (a_zero | b_zero)                  mul_y = {sa ^ sb, 31'd0};
    else                                       mul_y = fp_round(sa ^ sb, pe, pm);

    case (OPERATIONCODE)
      OP_ADD:  o_d = add_y;
      OP_SUB:  o_d = add_y;
      OP_MUL:  o_d = mul_y;
      default: o_d = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) o_q <= 32'h0000_0000;
    else     o_q <= o_d;
  end

  assign O = o_q;

endmodule

// File: tb/tb_alu.sv
// Random and directed checks of the binary32 ALU against an
// exact-arithmetic reference model.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic [31:0] o;
  int          n_chk = 0;
  int          n_bad = 0;

  localparam logic [31:0] NAN_C = 32'h7FC0_0000;

  always #5 clk = ~clk;

  alu #(.WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .A             (a),
    .B             (b),
    .OPERATIONCODE (op),
    .O             (o)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%08h exp=%08h (a=%08h b=%08h op=%0d)",
               tag, got, exp, a, b, op);
    end
  endtask

  // Round the exact value x * 2^e to binary32, nearest-even.
  function automatic logic [31:0] m_round(input logic s,
                                          input logic [127:0] x,
                                          input int e);
    int           p;
    int           sh;
    int           be;
    logic [127:0] keep;
    logic [127:0] rem;
    logic [127:0] half;
    logic         up;
    p = 0;
    for (int i = 0; i < 128; i++) if (x[i]) p = i;
    sh = p - 23;
    up = 1'b0;
    if (sh > 0) begin
      keep = x >> sh;
      rem  = x - (keep << sh);
      half = 128'd1 << (sh - 1);
      up   = (rem > half) || (rem == half && keep[0]);
    end else begin
      keep = x << (-sh);
    end
    keep = keep + {127'd0, up};
    if (keep[24]) begin
      keep = keep >> 1;
      sh++;
    end
    be = e + sh + 23 + 127;
    if (be >= 255) return {s, 8'hFF, 23'd0};
    if (be < 1)    return {s, 31'd0};
    return {s, be[7:0], keep[22:0]};
  endfunction

  function automatic logic [31:0] m_addsub(input logic [31:0] x,
                                           input logic [31:0] y,
                                           input logic sub);
    logic         sx, sy, st;
    int           ex, ey, et, d, e;
    logic [127:0] mx, my, mt, v;
    bit           xn, yn, xi, yi, xz, yz;
    sx = x[31];
    sy = y[31] ^ sub;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xn = ex == 255 && x[22:0] != 0;
    yn = ey == 255 && y[22:0] != 0;
    xi = ex == 255 && x[22:0] == 0;
    yi = ey == 255 && y[22:0] == 0;
    xz = ex == 0;
    yz = ey == 0;
    if (xn || yn) return NAN_C;
    if (xi && yi) return (sx == sy) ? x : NAN_C;
    if (xi) return x;
    if (yi) return {sy, 8'hFF, 23'd0};
    if (xz && yz) return {sx & sy, 31'd0};
    if (yz) return x;
    if (xz) return {sy, y[30:0]};
    mx = {104'd0, 1'b1, x[22:0]};
    my = {104'd0, 1'b1, y[22:0]};
    if (y[30:0] > x[30:0]) begin
      mt = mx; mx = my; my = mt;
      et = ex; ex = ey; ey = et;
      st = sx; sx = sy; sy = st;
    end
    d = ex - ey;
    if (d <= 60) begin
      v = (sx == sy) ? (mx << d) + my : (mx << d) - my;
      e = ey - 150;
    end else begin
      v = (sx == sy) ? (mx << 30) + 128'd1 : (mx << 30) - 128'd1;
      e = ex - 150 - 30;
    end
    if (v == 0) return 32'h0;
    return m_round(sx, v, e);
  endfunction

  function automatic logic [31:0] m_mul(input logic [31:0] x,
                                        input logic [31:0] y);
    logic s;
    int   ex, ey;
    bit   xn, yn, xi, yi, xz, yz;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xn = ex == 255 && x[22:0] != 0;
    yn = ey == 255 && y[22:0] != 0;
    xi = ex == 255 && x[22:0] == 0;
    yi = ey == 255 && y[22:0] == 0;
    xz = ex == 0;
    yz = ey == 0;
    if (xn || yn) return NAN_C;
    if ((xi && yz) || (xz && yi)) return NAN_C;
    if (xi || yi) return {s, 8'hFF, 23'd0};
    if (xz || yz) return {s, 31'd0};
    return m_round(s, {104'd0, 1'b1, x[22:0]} * {104'd0, 1'b1, y[22:0]},
                   (ex - 150) + (ey - 150));
  endfunction

  function automatic logic [31:0] model(input logic [2:0] c,
                                        input logic [31:0] x,
                                        input logic [31:0] y);
    case (c)
      3'd0:    return m_addsub(x, y, 1'b0);
      3'd1:    return m_addsub(x, y, 1'b1);
      3'd2:    return m_mul(x, y);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] rnd_op(input logic [31:0] near);
    logic [31:0] sp [8];
    logic [7:0]  e;
    sp = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
           32'h7FC0_0000, 32'h7F80_0001, 32'h0001_2345, 32'h3F80_0000};
    case ($urandom_range(0, 9))
      0: return sp[$urandom_range(0, 7)];
      1, 2, 3: begin
        e = near[30:23] + 8'($urandom_range(0, 4)) - 8'd2;
        return {1'($urandom), e, near[22:0] ^ 23'($urandom_range(0, 255))};
      end
      4: begin
        e = $urandom_range(0, 1) ? 8'($urandom_range(1, 70))
                                 : 8'($urandom_range(190, 254));
        return {1'($urandom), e, 23'($urandom)};
      end
      default: return $urandom;
    endcase
  endfunction

  task automatic run(input logic [2:0] c, input logic [31:0] x,
                     input logic [31:0] y, input string tag,
                     input logic [31:0] exp);
    op = c;
    a  = x;
    b  = y;
    @(posedge clk);
    #1;
    chk(tag, o, exp);
  endtask

  initial begin
    logic [31:0] x;
    logic [31:0] y;
    logic [2:0]  c;
    rst = 1'b1;
    op  = 3'd0;
    a   = 32'h3F80_0000;
    b   = 32'h4000_0000;
    @(posedge clk);
    #1;
    chk("reset", o, 32'h0);
    run(3'd2, 32'h4040_0000, 32'hC000_0000, "rst_override", 32'h0);
    rst = 1'b0;
    op  = 3'd1;
    a   = 32'h4000_0000;
    b   = 32'h3F80_0000;
    #3;
    chk("hold_before_edge", o, 32'h0);
    @(posedge clk);
    #1;
    chk("first_after_rst", o, 32'h3F80_0000);
    run(3'd7, 32'h4000_0000, 32'h3F80_0000, "reserved7", 32'h0);
    run(3'd0, 32'h3F80_0000, 32'h3F80_0000, "add_1p1", 32'h4000_0000);
    run(3'd2, 32'h4040_0000, 32'hC000_0000, "mul_3m2", 32'hC0C0_0000);
    run(3'd1, 32'h7F80_0000, 32'h7F80_0000, "inf_m_inf", 32'h7FC0_0000);
    run(3'd1, 32'hFDD7_32A0, 32'h415D_7A91, "sub_absorb", 32'hFDD7_32A0);
    run(3'd1, 32'h9A53_2950, 32'h8EF2_65DD, "sub_rne", 32'h9A53_294E);
    run(3'd1, 32'h503C_1372, 32'h6737_36D7, "sub_flip1", 32'hE737_36D7);
    run(3'd1, 32'h3E92_E21E, 32'hC5D9_8D58, "sub_flip2", 32'h45D9_8FA4);
    run(3'd1, 32'hE96C_7915, 32'hE495_0034, "sub_like1", 32'hE96C_2E95);
    run(3'd1, 32'h2340_06A6, 32'hADEA_76CB, "sub_like2", 32'h2DEA_76D1);
    run(3'd1, 32'h4120_0000, 32'h4120_0000, "sub_equal", 32'h0000_0000);
    run(3'd0, 32'hC120_0000, 32'h0000_0000, "add_zero", 32'hC120_0000);
    run(3'd2, 32'h0000_0000, 32'h7F80_0000, "mul_0inf", 32'h7FC0_0000);
    run(3'd2, 32'h7F00_0000, 32'h4000_0000, "mul_ovf", 32'h7F80_0000);
    run(3'd2, 32'h0080_0000, 32'h3F00_0000, "mul_unf", 32'h0000_0000);
    run(3'd0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, "add_ovf", 32'h7F80_0000);
    run(3'd2, 32'hC000_0000, 32'h0000_1234, "mul_denorm", 32'h8000_0000);
    run(3'd5, 32'h4000_0000, 32'h3F80_0000, "reserved5", 32'h0);

    x = $urandom;
    for (int i = 0; i < 3000; i++) begin
      x = rnd_op(x);
      y = rnd_op(x);
      c = 3'($urandom_range(0, 3));
      if (c == 3'd3) c = 3'($urandom_range(3, 7));
      run(c, x, y, "random", model(c, x, y));
    end

    rst = 1'b1;
    run(3'd0, 32'h3F80_0000, 32'h3F80_0000, "rst_midrun", 32'h0);
    rst = 1'b0;
    run(3'd0, 32'h3F80_0000, 32'h4000_0000, "after_midrun", 32'h4040_0000);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
